// File: rtl/i_cache_sa.sv
// Set-associative instruction cache with per-set tree-PLRU replacement, a
// single outstanding line fill, whole-cache flush and hit/miss counters.
//
// state | meaning
// IDLE  | lookup; accepts fetches, applies flushes
// REQ   | line-fill request held on the memory port
// WAIT  | waiting for the fill data
// RSP   | delivering the missed word to the core
module i_cache_sa #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_valid,
  input  logic [31:0]             core_req_pc,
  output logic                    core_req_ready,
  output logic                    core_rsp_valid,
  output logic [31:0]             core_rsp_instr,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_rsp_data,
  input  logic                    flush,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);
  localparam int WW  = $clog2(WAYS);
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - OFF - IDX;
  localparam int WS  = OFF - 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t                  state;
  logic                    valid_q [SETS][WAYS];
  logic [TAG-1:0]          tag_q   [SETS][WAYS];
  logic [32*LINE_WORDS-1:0] data_q [SETS][WAYS];
  logic [WAYS-2:0]         plru_q  [SETS];
  logic [29:0]             pc_q;
  logic [WW-1:0]           victim_q;
  logic                    flush_pend;

  // Tree bits in heap order: node n has children 2n+1 / 2n+2; bit 0 points left.
  function automatic logic [WW-1:0] plru_way(input logic [WAYS-2:0] t);
    int node;
    node = 0;
    for (int l = 0; l < WW; l++) node = 2 * node + 1 + int'(t[node]);
    return WW'(node - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [WW-1:0] w);
    logic [WAYS-2:0] r;
    int node;
    r = t;
    node = 0;
    for (int l = WW - 1; l >= 0; l--) begin
      r[node] = ~w[l];
      node = 2 * node + 1 + int'(w[l]);
    end
    return r;
  endfunction

  function automatic logic [31:0] pick_word(input logic [32*LINE_WORDS-1:0] line, input logic [WS-1:0] sel);
    return line[32*int'(sel) +: 32];
  endfunction

  logic [IDX-1:0] req_idx;
  logic [TAG-1:0] req_tag;
  logic [WS-1:0]  req_word;
  logic [IDX-1:0] fill_idx;
  logic [TAG-1:0] fill_tag;
  logic [WS-1:0]  fill_word;
  logic           unused_pc_bits;

  assign req_idx   = core_req_pc[OFF+IDX-1:OFF];
  assign req_tag   = core_req_pc[31:OFF+IDX];
  assign req_word  = core_req_pc[OFF-1:2];
  assign fill_idx  = pc_q[OFF+IDX-3:OFF-2];
  assign fill_tag  = pc_q[29:OFF+IDX-2];
  assign fill_word = pc_q[OFF-3:0];
  assign unused_pc_bits = ^core_req_pc[1:0];

  assign core_req_ready = (state == IDLE) & ~flush & ~flush_pend;

  logic                     hit;
  logic [WW-1:0]            hit_way;
  logic                     inv_found;
  logic [WW-1:0]            inv_way;
  logic [WW-1:0]            victim;
  logic [32*LINE_WORDS-1:0] hit_line;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim   = inv_found ? inv_way : plru_way(plru_q[req_idx]);
    hit_line = data_q[req_idx][hit_way];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      flush_pend     <= 1'b0;
      core_rsp_valid <= 1'b0;
      core_rsp_instr <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      pc_q           <= '0;
      victim_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      core_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              plru_q[s] <= '0;
              for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
            end
          end else if (core_req_valid) begin
            if (hit) begin
              core_rsp_valid   <= 1'b1;
              core_rsp_instr   <= pick_word(hit_line, req_word);
              plru_q[req_idx]  <= plru_touch(plru_q[req_idx], hit_way);
              hit_cnt          <= hit_cnt + 32'd1;
            end else begin
              pc_q          <= core_req_pc[31:2];
              victim_q      <= victim;
              miss_cnt      <= miss_cnt + 32'd1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {core_req_pc[31:OFF], {OFF{1'b0}}};
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_rsp_valid) begin
            data_q[fill_idx][victim_q]  <= mem_rsp_data;
            tag_q[fill_idx][victim_q]   <= fill_tag;
            valid_q[fill_idx][victim_q] <= 1'b1;
            plru_q[fill_idx]            <= plru_touch(plru_q[fill_idx], victim_q);
            core_rsp_valid              <= 1'b1;
            core_rsp_instr              <= pick_word(mem_rsp_data, fill_word);
            state                       <= RSP;
          end
        end
        RSP: begin
          if (flush) flush_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i_cache_sa.sv
// Bench for i_cache_sa: vector table, hand sequences for multi-cycle corners,
// and random fetches checked against a line-presence model.
module tb_i_cache_sa;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         core_req_valid = 1'b0;
  logic [31:0]  core_req_pc = '0;
  logic         core_req_ready;
  logic         core_rsp_valid;
  logic [31:0]  core_rsp_instr;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;
  logic         flush = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  i_cache_sa #(.WAYS(4), .SETS(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_pc(core_req_pc),
    .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
    .core_rsp_instr(core_rsp_instr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_cfg = 0;
  int lat_cfg = 1;
  int last_rsp_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: holds ready low for stall_cfg cycles, answers lat_cfg cycles after the grant.
  initial begin
    bit in_req;
    int stall_left;
    int fill_cnt;
    logic [31:0] fill_addr;
    in_req = 0; stall_left = 0; fill_cnt = 0; fill_addr = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (fill_cnt > 0) begin
        fill_cnt--;
        if (fill_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          for (int w = 0; w < 4; w++) mem_rsp_data[32*w +: 32] = mem_word(fill_addr + 32'(4 * w));
          last_rsp_cyc = cyc;
        end
      end else if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          in_req = 0;
          fill_addr = mem_req_addr;
          fill_cnt = lat_cfg;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One fetch; returns the delivered word and whether it went to memory.
  task automatic fetch(input logic [31:0] pc, input int flush_at, input int stall, input int lat_mem,
                       output logic [31:0] instr, output bit was_miss);
    logic [31:0] addr0;
    int reqc, n, lat;
    bit addr_ok, rdy_ok;
    stall_cfg = stall;
    lat_cfg = lat_mem;
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_pc = pc;
    #1;
    n = 0;
    while (!core_req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready", {31'd0, core_req_ready}, 32'd1);
    @(negedge clk);
    core_req_valid = 1'b0;
    lat = 1; reqc = 0; addr_ok = 1; rdy_ok = 1; addr0 = '0;
    while (!core_rsp_valid && lat < 200) begin
      if (mem_req_valid) begin
        if (reqc == 0) addr0 = mem_req_addr;
        else if (mem_req_addr !== addr0) addr_ok = 0;
        reqc++;
      end
      if (core_req_ready) rdy_ok = 0;
      flush = (lat == flush_at);
      @(negedge clk);
      lat++;
    end
    flush = 1'b0;
    chk("rsp_valid", {31'd0, core_rsp_valid}, 32'd1);
    instr = core_rsp_instr;
    was_miss = (lat > 1);
    if (was_miss) begin
      chk("fill_addr", addr0, pc & ~32'hF);
      chk("req_cycles", 32'(reqc), 32'(stall + 1));
      chk("req_addr_stable", {31'd0, addr_ok}, 32'd1);
      chk("ready_low_in_miss", {31'd0, rdy_ok}, 32'd1);
      chk("miss_latency", 32'(cyc - last_rsp_cyc), 32'd1);
    end
  endtask

  typedef struct {
    bit          do_rst;
    logic [31:0] pc;
    bit          exp_hit;
  } vec_t;

  vec_t vecs[17];
  bit present[logic [31:0]];

  initial begin
    logic [31:0] instr;
    bit miss;
    int exp_h, exp_m;
    bit bad;

    vecs[0]  = '{1'b1, 32'h0000_0104, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 1'b1};
    vecs[2]  = '{1'b0, 32'h0000_0108, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_010C, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0110, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_011C, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0106, 1'b1};
    // Set 0 replacement: fills ways 0..3, re-touches way 0, then 0x400 evicts 0x200.
    vecs[7]  = '{1'b1, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0200, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0300, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0004, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0400, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0100, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_0300, 1'b1};
    vecs[16] = '{1'b0, 32'h0000_0200, 1'b0};

    do_reset();
    #1;
    chk("rst_ready", {31'd0, core_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
    chk("rst_rsp_instr", core_rsp_instr, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);

    exp_h = 0; exp_m = 0;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_rst) begin
        if (i > 0) begin
          chk("tbl_hit_cnt", hit_cnt, 32'(exp_h));
          chk("tbl_miss_cnt", miss_cnt, 32'(exp_m));
        end
        do_reset();
        exp_h = 0; exp_m = 0;
      end
      fetch(vecs[i].pc, 0, i % 3, 1 + i % 2, instr, miss);
      chk($sformatf("tbl%0d_instr", i), instr, mem_word(vecs[i].pc & ~32'h3));
      chk($sformatf("tbl%0d_hit", i), {31'd0, ~miss}, {31'd0, vecs[i].exp_hit});
      if (vecs[i].exp_hit) exp_h++; else exp_m++;
    end
    chk("tbl_hit_cnt", hit_cnt, 32'(exp_h));
    chk("tbl_miss_cnt", miss_cnt, 32'(exp_m));

    // Back-to-back hit stream: one response per cycle, no memory traffic.
    do_reset();
    fetch(32'h0000_0104, 0, 0, 1, instr, miss);
    chk("cold_miss_instr", instr, mem_word(32'h104));
    chk("cold_miss_cnt", miss_cnt, 32'd1);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stream_rsp_valid", {31'd0, core_rsp_valid}, 32'd1);
        chk("stream_instr", core_rsp_instr, mem_word(32'h100 + 32'(4 * (i - 1))));
        chk("stream_no_mem", {31'd0, mem_req_valid}, 32'd0);
      end
      if (i < 4) begin
        core_req_valid = 1'b1;
        core_req_pc = 32'h100 + 32'(4 * i);
      end else core_req_valid = 1'b0;
    end
    chk("stream_hit_cnt", hit_cnt, 32'd4);

    // Memory backpressure for 5 cycles.
    fetch(32'h0000_0508, 0, 5, 2, instr, miss);
    chk("bp_instr", instr, mem_word(32'h508));
    chk("bp_miss", {31'd0, miss}, 32'd1);

    // Flush during WAIT: response still delivered, then one cycle of ready low.
    do_reset();
    fetch(32'h0000_0200, 2, 0, 4, instr, miss);
    chk("flushwait_instr", instr, mem_word(32'h200));
    @(negedge clk);
    #1;
    chk("flush_hold_ready", {31'd0, core_req_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("flush_release_ready", {31'd0, core_req_ready}, 32'd1);
    fetch(32'h0000_0200, 0, 0, 1, instr, miss);
    chk("flush_refetch_miss", {31'd0, miss}, 32'd1);
    chk("flush_miss_cnt", miss_cnt, 32'd2);

    // Reset in WAIT; the late fill response must be ignored.
    do_reset();
    stall_cfg = 0;
    lat_cfg = 6;
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_pc = 32'h0000_0600;
    @(negedge clk);
    core_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, core_req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
    chk("midrst_mem_req", {31'd0, mem_req_valid}, 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    chk("midrst_hit_cnt", hit_cnt, 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_rsp_valid) bad = 1;
    end
    chk("late_rsp_ignored", {31'd0, bad}, 32'd0);
    fetch(32'h0000_0600, 0, 0, 1, instr, miss);
    chk("late_rsp_no_fill", {31'd0, miss}, 32'd1);
    chk("late_rsp_instr", instr, mem_word(32'h600));

    // Random fetches; at most 4 tags per set so nothing is ever evicted.
    do_reset();
    present.delete();
    exp_h = 0; exp_m = 0;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] pc;
      bit exp_hit;
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("idle_flush_ready", {31'd0, core_req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        present.delete();
      end
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      exp_hit = present.exists(pc & ~32'hF);
      fetch(pc, 0, $urandom_range(0, 3), $urandom_range(1, 3), instr, miss);
      chk("rand_instr", instr, mem_word(pc & ~32'h3));
      chk("rand_hit", {31'd0, ~miss}, {31'd0, exp_hit});
      present[pc & ~32'hF] = 1'b1;
      if (exp_hit) exp_h++; else exp_m++;
    end
    chk("rand_hit_cnt", hit_cnt, 32'(exp_h));
    chk("rand_miss_cnt", miss_cnt, 32'(exp_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
